// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch sequencer's memory, decode, redirect and status signals.
// The master modport is the sequencer side; slave is its surrounding front end.
interface fetch_sequencer_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        fetch_error;
  logic [31:0] retired_count;

  modport master (
    output imem_addr,
    input  imem_data,
    output inst_valid,
    input  inst_ready,
    output inst_code,
    output inst_pc,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    output halted,
    output fetch_error,
    output retired_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  inst_valid,
    output inst_ready,
    input  inst_code,
    input  inst_pc,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    input  halted,
    input  fetch_error,
    input  retired_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, fetches into a 2-entry queue and
// hands words to decode, handling redirects, halts and misaligned-target faults.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clock,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [1:0]  count_r;
  logic [1:0]  count_next_s;
  logic        error_r;
  logic        error_next_s;
  logic [31:0] retired_r;
  logic [31:0] q_pc_r   [0:1];
  logic [31:0] q_code_r [0:1];
  logic        pop_s;
  logic        fetch_s;
  logic        push_slot_s;

  assign bus.imem_addr     = pc_r;
  assign bus.inst_valid    = (count_r != 2'd0);
  assign bus.inst_code     = q_code_r[0];
  assign bus.inst_pc       = q_pc_r[0];
  assign bus.halted        = (state_r == HALT);
  assign bus.fetch_error   = error_r;
  assign bus.retired_count = retired_r;

  // Next-state, PC and queue-occupancy decisions; redirect overrides halt and fetch.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    count_next_s = count_r;
    error_next_s = error_r;
    pop_s        = (count_r != 2'd0) && bus.inst_ready;
    fetch_s      = (state_r == RUN) && !bus.redirect_valid && !bus.halt_req &&
                   ((count_r != 2'd2) || pop_s);
    push_slot_s  = (count_r == 2'd2) || ((count_r == 2'd1) && !pop_s);
    case (state_r)
      IDLE:    state_next_s = RUN;
      RUN: begin
        if (bus.halt_req) begin
          state_next_s = HALT;
        end else begin
          state_next_s = RUN;
        end
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = IDLE;
    endcase
    if (bus.redirect_valid) begin
      count_next_s = 2'd0;
      if (bus.redirect_pc[1:0] == 2'b00) begin
        pc_next_s    = bus.redirect_pc;
        state_next_s = RUN;
      end else begin
        error_next_s = 1'b1;
        state_next_s = HALT;
      end
    end else begin
      count_next_s = count_r - {1'b0, pop_s} + {1'b0, fetch_s};
      if (fetch_s) begin
        pc_next_s = pc_r + 32'd4;
      end else begin
        pc_next_s = pc_r;
      end
    end
  end

  // Control registers and retirement counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      pc_r      <= RESET_PC;
      count_r   <= 2'd0;
      error_r   <= 1'b0;
      retired_r <= 32'd0;
    end else begin
      state_r   <= state_next_s;
      pc_r      <= pc_next_s;
      count_r   <= count_next_s;
      error_r   <= error_next_s;
      retired_r <= retired_r + {31'd0, pop_s};
    end
  end

  // Shift queue: slot 0 is the head; a push lands in the first free slot after the pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_pc_r[0]   <= 32'd0;
      q_pc_r[1]   <= 32'd0;
      q_code_r[0] <= 32'd0;
      q_code_r[1] <= 32'd0;
    end else begin
      if (pop_s) begin
        q_pc_r[0]   <= q_pc_r[1];
        q_code_r[0] <= q_code_r[1];
      end
      if (fetch_s) begin
        q_pc_r[push_slot_s]   <= pc_r;
        q_code_r[push_slot_s] <= bus.imem_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against a queue-based
// behavioural model of the fetch rules.
module tb_fetch_sequencer;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = {a[7:0], a[31:8]} ^ 32'hC3C3_0F0F;
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  // Reference model: program counter, mode and a queue of fetched PCs.
  logic [31:0] m_pc;
  int          m_mode;    // 0 idle, 1 run, 2 halt
  logic        m_err;
  logic [31:0] m_ret;
  logic [31:0] m_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("inst_valid", {31'd0, bus.inst_valid}, {31'd0, (m_q.size() != 0)});
    check_eq("halted", {31'd0, bus.halted}, {31'd0, (m_mode == 2)});
    check_eq("fetch_error", {31'd0, bus.fetch_error}, {31'd0, m_err});
    check_eq("retired_count", bus.retired_count, m_ret);
    check_eq("imem_addr", bus.imem_addr, m_pc);
    if (m_q.size() != 0) begin
      check_eq("inst_pc", bus.inst_pc, m_q[0]);
      check_eq("inst_code", bus.inst_code, mem_word(m_q[0]));
    end
  endtask

  task automatic model_step(input logic rst, input logic rv, input logic [31:0] rpc,
                            input logic hr, input logic rdy);
    if (rst) begin
      m_q.delete();
      m_pc   = 32'h0000_0000;
      m_mode = 0;
      m_err  = 1'b0;
      m_ret  = 32'd0;
    end else begin
      if (m_q.size() != 0 && rdy) begin
        m_ret = m_ret + 32'd1;
        void'(m_q.pop_front());
      end
      if (rv) begin
        m_q.delete();
        if (rpc % 4 == 0) begin
          m_pc   = rpc;
          m_mode = 1;
        end else begin
          m_err  = 1'b1;
          m_mode = 2;
        end
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (hr) begin
          m_mode = 2;
        end else if (m_q.size() < 2) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // Called at a falling edge: check, drive, advance one clock, return at next falling edge.
  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc,
                      input logic hr, input logic rdy);
    check_outputs();
    reset              = rst;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.halt_req       = hr;
    bus.inst_ready     = rdy;
    model_step(rst, rv, rpc, hr, rdy);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_reset_zero();
    check_eq("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check_eq("rst_code", bus.inst_code, 32'd0);
    check_eq("rst_pc", bus.inst_pc, 32'd0);
    check_eq("rst_halted", {31'd0, bus.halted}, 32'd0);
    check_eq("rst_error", {31'd0, bus.fetch_error}, 32'd0);
    check_eq("rst_retired", bus.retired_count, 32'd0);
    check_eq("rst_addr", bus.imem_addr, 32'd0);
  endtask

  initial begin
    logic [31:0] head_code;
    logic [31:0] rpc;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.halt_req       = 1'b0;
    bus.inst_ready     = 1'b0;
    m_pc = 32'd0; m_mode = 0; m_err = 1'b0; m_ret = 32'd0;
    @(negedge clock);
    model_step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    check_reset_zero();

    // Streaming: first valid two cycles after reset falls, then 0,4,8,...
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("idle_no_valid", {31'd0, bus.inst_valid}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("first_pc", bus.inst_pc, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("second_pc", bus.inst_pc, 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Stall: queue fills, PC sits 8 past the head, head word stable.
    head_code = bus.inst_code;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check_eq("stall_code", bus.inst_code, head_code);
    check_eq("stall_pc_ahead", bus.imem_addr, bus.inst_pc + 32'd8);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Redirect while full and handshaking.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
    check_eq("redir_bubble", {31'd0, bus.inst_valid}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("redir_target", bus.inst_pc, 32'h0000_0100);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Misaligned redirect faults and halts; aligned redirect resumes.
    step(1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b1);
    check_eq("mis_halted", {31'd0, bus.halted}, 32'd1);
    check_eq("mis_error", {31'd0, bus.fetch_error}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("err_sticky", {31'd0, bus.fetch_error}, 32'd1);

    // Halt with an entry queued, then simultaneous halt and redirect.
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b1);
    check_eq("halt_redir_run", {31'd0, bus.halted}, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Address wrap.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("wrap_top", bus.inst_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("wrap_zero", bus.inst_pc, 32'h0000_0000);

    // Reset mid-stream.
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    check_reset_zero();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 9) == 0),
           rpc,
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) != 0));
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
